// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MUL_EN: single-cycle MUL* using a registered wide product.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [2:0]      op;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] hi, lo, mag_b;
    logic            neg, sa;

    logic            accept, last;
    logic            sgn_a, sgn_b, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, ovf, special, fast, early;
    logic [XLEN-1:0] special_val, fast_val, early_val;

    assign accept = start && !flush && (state != BUSY);
    assign last   = (state == BUSY) && (cnt == CW'(XLEN - 1));

    // Signedness of each operand by funct3
    assign sgn_a = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
    assign sgn_b = funct3[2] ? !funct3[0] : !funct3[1];
    assign a_neg = sgn_a && op_a[XLEN-1];
    assign b_neg = sgn_b && op_b[XLEN-1];
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

    assign div_zero = funct3[2] && (op_b == '0);
    assign ovf      = funct3[2] && !funct3[0] && (op_b == '1)
                   && (op_a == {1'b1, {(XLEN-1){1'b0}}});
    assign special  = div_zero || ovf;
    assign special_val = div_zero ? (funct3[1] ? op_a : '1)
                                  : (funct3[1] ? '0 : op_a);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fa, fb;
    logic signed [2*XLEN+1:0] fp;
    assign fa = $signed({a_neg, op_a});
    assign fb = $signed({b_neg, op_b});
    assign fp = fa * fb;
    assign fast = !funct3[2];
    assign fast_val = (funct3 == 3'b000) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
`else
    assign fast = 1'b0;
    assign fast_val = '0;
`endif

    assign early     = special || fast;
    assign early_val = special ? special_val : fast_val;

    // One iteration: hi/lo hold product halves or remainder/quotient
    logic [XLEN:0]     sum, sh, tr;
    logic [XLEN-1:0]   hi_n, lo_n, q_fix, r_fix, fin_val;
    logic [2*XLEN-1:0] prod, prod_s;

    always_comb begin
        sum = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
        sh  = {hi, lo[XLEN-1]};
        tr  = sh - {1'b0, mag_b};
        if (op[2]) begin
            hi_n = tr[XLEN] ? sh[XLEN-1:0] : tr[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], ~tr[XLEN]};
        end else begin
            hi_n = sum[XLEN:1];
            lo_n = {sum[0], lo[XLEN-1:1]};
        end
        prod   = {hi_n, lo_n};
        prod_s = neg ? -prod : prod;
        q_fix  = neg ? -lo_n : lo_n;
        r_fix  = sa ? -hi_n : hi_n;
        if (op[2])
            fin_val = op[1] ? r_fix : q_fix;
        else if (op == 3'b000)
            fin_val = prod_s[XLEN-1:0];
        else
            fin_val = prod_s[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept)
                        state_n = early ? DONE : BUSY;
                    else
                        state_n = IDLE;
                end
                BUSY: if (last) state_n = DONE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            rd_out <= '0;
            cnt    <= '0;
            op     <= '0;
            rd_q   <= '0;
            hi     <= '0;
            lo     <= '0;
            mag_b  <= '0;
            neg    <= 1'b0;
            sa     <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n != IDLE);
            done  <= (state_n == DONE);
            if (accept) begin
                op    <= funct3;
                rd_q  <= rd_in;
                mag_b <= b_mag;
                neg   <= a_neg ^ b_neg;
                sa    <= a_neg;
                hi    <= '0;
                lo    <= a_mag;
                cnt   <= '0;
                if (early) begin
                    result <= early_val;
                    rd_out <= rd_in;
                end
            end else if (state == BUSY && !flush) begin
                hi  <= hi_n;
                lo  <= lo_n;
                cnt <= cnt + 1'b1;
                if (last) begin
                    result <= fin_val;
                    rd_out <= rd_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Expected values are hand-computed RV32M results.
module tb_muldiv_unit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int tests = 0;
    int fails = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge where done is seen
    task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          output int lat);
        start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            if (done) break;
        end
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] prev;
        rst_n = 1'b0; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        rd_in = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_rd", 32'(rd_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, lat);
        check("mul_lat", 32'(lat), 32'(MUL_LAT));
        check("mul_res", result, 32'hFFFF_FFEB);
        check("mul_rd", 32'(rd_out), 32'd5);
        check("mul_busy_in_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("mul_done_pulse", 32'(done), 32'd0);
        check("mul_idle_busy", 32'(busy), 32'd0);

        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, lat);
        check("mulhu_res", result, 32'hFFFF_FFFE);
        check("mulhu_lat", 32'(lat), 32'(MUL_LAT));
        @(negedge clk);

        run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd7, lat);
        check("mulhsu_res", result, 32'hFFFF_FFFF);
        @(negedge clk);

        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd8, lat);
        check("mulh_res", result, 32'h4000_0000);
        @(negedge clk);

        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, lat);
        check("div_lat", 32'(lat), 32'd33);
        check("div_res", result, 32'hFFFF_FFFD);
        // Back-to-back issue in the DONE cycle
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10, lat);
        check("b2b_rem_lat", 32'(lat), 32'd33);
        check("rem_res", result, 32'hFFFF_FFFF);
        check("rem_rd", 32'(rd_out), 32'd10);
        @(negedge clk);

        run_op(3'b101, 32'd20, 32'd0, 5'd11, lat);
        check("divu0_lat", 32'(lat), 32'd1);
        check("divu0_res", result, 32'hFFFF_FFFF);
        @(negedge clk);
        run_op(3'b111, 32'd20, 32'd0, 5'd12, lat);
        check("remu0_res", result, 32'd20);
        @(negedge clk);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, lat);
        check("rem_ovf_lat", 32'(lat), 32'd1);
        check("rem_ovf_res", result, 32'h0);
        @(negedge clk);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, lat);
        check("div_ovf_res", result, 32'h8000_0000);
        @(negedge clk);
        run_op(3'b111, 32'd100, 32'd7, 5'd15, lat);
        check("remu_res", result, 32'd2);
        @(negedge clk);

        // Flush on edge 10 of an in-flight divide
        prev = result;
        start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
        rd_in = 5'd3;
        lat = 0; seen = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            if (done) seen = 1;
            if (lat == 9) flush = 1'b1;
            if (lat == 10) begin
                flush = 1'b0;
                check("flush_busy", 32'(busy), 32'd0);
            end
        end
        check("flush_nodone", 32'(seen), 32'd0);
        check("flush_keep_res", result, prev);
        check("flush_keep_rd", 32'(rd_out), 32'd15);

        run_op(3'b101, 32'd100, 32'd7, 5'd3, lat);
        check("divu_lat", 32'(lat), 32'd33);
        check("divu_res", result, 32'd14);
        check("divu_rd", 32'(rd_out), 32'd3);
        @(negedge clk);

        // Second start while BUSY is ignored
        start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
        rd_in = 5'd7;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            if (lat == 5) begin
                start = 1'b1; funct3 = 3'b011; op_a = 32'hFFFF_FFFF;
                op_b = 32'hFFFF_FFFF; rd_in = 5'd9;
            end
            if (lat == 6) start = 1'b0;
            if (done) break;
        end
        check("ign_lat", 32'(lat), 32'd33);
        check("ign_res", result, 32'd14);
        check("ign_rd", 32'(rd_out), 32'd7);
        @(negedge clk);
        check("ign_no_second", 32'(busy), 32'd0);

        // Async reset mid-operation
        start = 1'b1; funct3 = 3'b100; op_a = 32'hFFFF_FFF9; op_b = 32'd2;
        rd_in = 5'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_result", result, 32'h0);
        check("arst_rd", 32'(rd_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("arst_nodone", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
